// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
//
// Behavioural data-memory slave for a simple core bus. It accepts one request
// at a time, optionally inserts wait states, and then answers with a one-cycle
// active-low ready strobe. Loads drive right-justified, zero-extended data on
// the shared ddata bus. Stores commit with byte enables.
//
// Optional feature macro: DMEM_RESPONDER_WAIT_EN
//   defined   : BUSY state, wait counter and dbusy are built (WAIT_CYCLES used)
//   undefined : every request goes IDLE -> RESP, dbusy is tied low
//
// Ports
//   clk       in   1   rising-edge clock
//   rst       in   1   synchronous active-high reset
//   dreq      in   1   request strobe
//   dwrite    in   1   1 = store, 0 = load (valid with dreq)
//   daddr     in   32  byte address (valid with dreq)
//   dsize     in   2   00 byte, 01 half, 10/11 word
//   ddata     inout 32 store data in / load data out (driven only in RESP)
//   dready_n  out  1   active-low response strobe, one cycle per request
//   dbusy     out  1   high during wait states
// -----------------------------------------------------------------------------
module dmem_responder #(
    parameter int          DEPTH_WORDS = 4096,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dreq,
    input  logic        dwrite,
    input  logic [31:0] daddr,
    input  logic [1:0]  dsize,
    inout  wire  [31:0] ddata,
    output logic        dready_n,
    output logic        dbusy
);

    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
`ifdef DMEM_RESPONDER_WAIT_EN
        S_BUSY = 2'd1,
`endif
        S_RESP = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic        dready_n_q, dready_n_d;
    logic        dbusy_q, dbusy_d;
    logic [31:0] addr_q;
    logic [1:0]  size_q;
    logic        write_q;
    logic [31:0] wdata_q;
`ifdef DMEM_RESPONDER_WAIT_EN
    logic [3:0]  cnt_q, cnt_d;
`endif

    logic [31:0] mem [DEPTH_WORDS];

    logic        accept;
    assign accept = (state_q == S_IDLE) && dreq;

    // ---------------------------------------------------------------- FSM ---
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        state_d    = state_q;
        dready_n_d = 1'b1;
        dbusy_d    = 1'b0;
`ifdef DMEM_RESPONDER_WAIT_EN
        cnt_d      = cnt_q;
`endif
        // Outputs are computed for the *next* state so that the registered
        // strobes line up exactly with the state they describe.
        case (state_q)
            S_IDLE: begin
                if (dreq) begin
`ifdef DMEM_RESPONDER_WAIT_EN
                    if (WAIT_CYCLES > 0) begin
                        state_d = S_BUSY;
                        cnt_d   = 4'(WAIT_CYCLES - 1);
                        dbusy_d = 1'b1;
                    end else begin
                        state_d    = S_RESP;
                        dready_n_d = 1'b0;
                    end
`else
                    state_d    = S_RESP;
                    dready_n_d = 1'b0;
`endif
                end
            end
`ifdef DMEM_RESPONDER_WAIT_EN
            S_BUSY: begin
                if (cnt_q == 4'd0) begin
                    state_d    = S_RESP;
                    dready_n_d = 1'b0;
                end else begin
                    cnt_d   = cnt_q - 4'd1;
                    dbusy_d = 1'b1;
                end
            end
`endif
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            state_q    <= S_IDLE;
            dready_n_q <= 1'b1;
            dbusy_q    <= 1'b0;
`ifdef DMEM_RESPONDER_WAIT_EN
            cnt_q      <= 4'd0;
`endif
        end else begin
            state_q    <= state_d;
            dready_n_q <= dready_n_d;
            dbusy_q    <= dbusy_d;
`ifdef DMEM_RESPONDER_WAIT_EN
            cnt_q      <= cnt_d;
`endif
        end
    end

    // Request holding registers are pure datapath: they are only consumed
    // after a fresh acceptance, so they carry no reset.
    always_ff @(posedge clk) begin
        if (accept && !rst) begin
            addr_q  <= daddr;
            size_q  <= dsize;
            write_q <= dwrite;
            wdata_q <= ddata;
        end
    end

    assign dready_n = dready_n_q;
    assign dbusy    = dbusy_q;

    // ------------------------------------------------------ address decode ---
    // A 33-bit subtraction exposes a borrow for addresses below BASE_ADDR and
    // avoids overflow when BASE_ADDR + 4*DEPTH_WORDS wraps past 2^32.
    logic [32:0]   diff;
    logic [31:0]   offset;
    logic          in_range;
    logic [AW-1:0] idx;

    assign diff     = {1'b0, addr_q} - {1'b0, BASE_ADDR};
    assign offset   = diff[31:0];
    assign in_range = !diff[32] && (offset < 32'(4 * DEPTH_WORDS));
    assign idx      = offset[AW+1:2];

    // ---------------------------------------------------------- store path ---
    logic [3:0]  be;
    logic [31:0] wlane;

    always_comb begin
        case (size_q)
            2'b00: begin
                be    = 4'b0001 << offset[1:0];
                wlane = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                be    = offset[1] ? 4'b1100 : 4'b0011;
                wlane = {2{wdata_q[15:0]}};
            end
            default: begin
                be    = 4'b1111;
                wlane = wdata_q;
            end
        endcase
    end

    // NOTE: the backing store has no reset; its contents must survive rst.
    // A reset coinciding with RESP abandons the request, so it blocks the commit.
    always_ff @(posedge clk) begin
        if (!rst && state_q == S_RESP && write_q && in_range) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[idx][8*i +: 8] <= wlane[8*i +: 8];
            end
        end
    end

    // ----------------------------------------------------------- load path ---
    logic [31:0] rword;
    logic [31:0] rdata;
    logic [31:0] rshift;
    logic        drive_load;

    assign rword  = mem[idx];
    assign rshift = rword >> {offset[1:0], 3'b000};

    always_comb begin
        case (size_q)
            2'b00:   rdata = {24'h0, rshift[7:0]};
            2'b01:   rdata = {16'h0, (offset[1] ? rword[31:16] : rword[15:0])};
            default: rdata = rword;
        endcase
        if (!in_range) rdata = 32'h0;
    end

    assign drive_load = (state_q == S_RESP) && !write_q && !rst;
    assign ddata      = drive_load ? rdata : {32{1'bz}};

endmodule

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
//
// Directed bench for dmem_responder with the default geometry (4096 words at
// base 0) and WAIT_CYCLES = 2. The effective wait count follows the
// DMEM_RESPONDER_WAIT_EN macro so the same bench covers both builds.
// -----------------------------------------------------------------------------
module tb_dmem_responder;

`ifdef DMEM_RESPONDER_WAIT_EN
    localparam int W = 2;
`else
    localparam int W = 0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        dreq;
    logic        dwrite;
    logic [31:0] daddr;
    logic [1:0]  dsize;
    wire  [31:0] ddata;
    logic        dready_n;
    logic        dbusy;

    logic        tb_drv;
    logic [31:0] tb_wdata;

    int n_tests = 0;
    int n_fail  = 0;

    assign ddata = tb_drv ? tb_wdata : {32{1'bz}};

    always #5 clk = ~clk;

    dmem_responder #(
        .DEPTH_WORDS (4096),
        .BASE_ADDR   (32'h0000_0000),
        .WAIT_CYCLES (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .dreq     (dreq),
        .dwrite   (dwrite),
        .daddr    (daddr),
        .dsize    (dsize),
        .ddata    (ddata),
        .dready_n (dready_n),
        .dbusy    (dbusy)
    );

    // One request; returns load data, cycle of the ready pulse (-1 on timeout)
    // counted from the acceptance edge, and number of dbusy cycles seen.
    task automatic access(input logic wr, input logic [31:0] addr,
                          input logic [1:0] sz, input logic [31:0] wd,
                          output logic [31:0] rd, output int lat, output int busy);
        @(negedge clk);
        dreq = 1'b1; dwrite = wr; daddr = addr; dsize = sz;
        tb_drv = wr; tb_wdata = wd;
        @(posedge clk);
        #1;
        dreq = 1'b0; tb_drv = 1'b0;
        lat = -1; busy = 0; rd = '0;
        for (int k = 1; k <= 20 && lat < 0; k++) begin
            @(negedge clk);
            if (dbusy) busy++;
            if (!dready_n) begin
                lat = k;
                rd  = ddata;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; dreq = 1'b0; dwrite = 1'b0; daddr = '0; dsize = 2'b10;
        tb_drv = 1'b0; tb_wdata = '0;
        repeat (3) @(negedge clk);
        n_tests++;
        if (dready_n !== 1'b1) begin
            n_fail++; $display("FAIL reset_dready_n: got %b expected 1", dready_n);
        end
        n_tests++;
        if (dbusy !== 1'b0) begin
            n_fail++; $display("FAIL reset_dbusy: got %b expected 0", dbusy);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_word();
        logic [31:0] rd; int lat; int busy;
        access(1'b1, 32'h100, 2'b10, 32'hDEADBEEF, rd, lat, busy);
        n_tests++;
        if (lat !== W + 1) begin
            n_fail++; $display("FAIL word_store_latency: got %0d expected %0d", lat, W + 1);
        end
        access(1'b0, 32'h100, 2'b10, 32'h0, rd, lat, busy);
        n_tests++;
        if (rd !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL word_load_data: got %h expected deadbeef", rd);
        end
        n_tests++;
        if (lat !== W + 1) begin
            n_fail++; $display("FAIL word_load_latency: got %0d expected %0d", lat, W + 1);
        end
        n_tests++;
        if (busy !== W) begin
            n_fail++; $display("FAIL word_load_dbusy_cycles: got %0d expected %0d", busy, W);
        end
        @(negedge clk);
        n_tests++;
        if (dready_n !== 1'b1) begin
            n_fail++; $display("FAIL word_single_pulse: got %b expected 1", dready_n);
        end
    endtask

    task automatic test_byte();
        logic [31:0] rd; int lat; int busy;
        access(1'b1, 32'h101, 2'b00, 32'hFFFFFF5A, rd, lat, busy);
        access(1'b0, 32'h100, 2'b10, 32'h0, rd, lat, busy);
        n_tests++;
        if (rd !== 32'hDEAD5AEF) begin
            n_fail++; $display("FAIL byte_store_merge: got %h expected dead5aef", rd);
        end
        access(1'b0, 32'h103, 2'b00, 32'h0, rd, lat, busy);
        n_tests++;
        if (rd !== 32'h000000DE) begin
            n_fail++; $display("FAIL byte_load_lane3: got %h expected 000000de", rd);
        end
        access(1'b0, 32'h100, 2'b00, 32'h0, rd, lat, busy);
        n_tests++;
        if (rd !== 32'h000000EF) begin
            n_fail++; $display("FAIL byte_load_lane0: got %h expected 000000ef", rd);
        end
    endtask

    task automatic test_half();
        logic [31:0] rd; int lat; int busy;
        access(1'b0, 32'h102, 2'b01, 32'h0, rd, lat, busy);
        n_tests++;
        if (rd !== 32'h0000DEAD) begin
            n_fail++; $display("FAIL half_load_upper: got %h expected 0000dead", rd);
        end
        access(1'b0, 32'h103, 2'b01, 32'h0, rd, lat, busy);
        n_tests++;
        if (rd !== 32'h0000DEAD) begin
            n_fail++; $display("FAIL half_load_misaligned: got %h expected 0000dead", rd);
        end
        access(1'b0, 32'h101, 2'b01, 32'h0, rd, lat, busy);
        n_tests++;
        if (rd !== 32'h00005AEF) begin
            n_fail++; $display("FAIL half_load_lower: got %h expected 00005aef", rd);
        end
        access(1'b1, 32'h102, 2'b01, 32'hFFFF1234, rd, lat, busy);
        access(1'b0, 32'h103, 2'b11, 32'h0, rd, lat, busy);
        n_tests++;
        if (rd !== 32'h12345AEF) begin
            n_fail++; $display("FAIL half_store_size3_load: got %h expected 12345aef", rd);
        end
    endtask

    task automatic test_out_of_range();
        logic [31:0] rd; int lat; int busy;
        access(1'b1, 32'h0, 2'b10, 32'h11111111, rd, lat, busy);
        access(1'b0, 32'h4000, 2'b10, 32'h0, rd, lat, busy);
        n_tests++;
        if (rd !== 32'h0) begin
            n_fail++; $display("FAIL oor_load_data: got %h expected 00000000", rd);
        end
        n_tests++;
        if (lat !== W + 1) begin
            n_fail++; $display("FAIL oor_load_latency: got %0d expected %0d", lat, W + 1);
        end
        access(1'b1, 32'h4000, 2'b10, 32'hFFFFFFFF, rd, lat, busy);
        n_tests++;
        if (lat !== W + 1) begin
            n_fail++; $display("FAIL oor_store_latency: got %0d expected %0d", lat, W + 1);
        end
        access(1'b0, 32'h0, 2'b10, 32'h0, rd, lat, busy);
        n_tests++;
        if (rd !== 32'h11111111) begin
            n_fail++; $display("FAIL oor_store_word0: got %h expected 11111111", rd);
        end
        access(1'b0, 32'h100, 2'b10, 32'h0, rd, lat, busy);
        n_tests++;
        if (rd !== 32'h12345AEF) begin
            n_fail++; $display("FAIL oor_store_word40: got %h expected 12345aef", rd);
        end
    endtask

    task automatic test_back_to_back();
        int pulses = 0;
        int bad    = 0;
        @(negedge clk);
        dreq = 1'b1; dwrite = 1'b0; daddr = 32'h100; dsize = 2'b10;
        for (int k = 1; k <= 4 * (W + 2); k++) begin
            @(negedge clk);
            if (!dready_n) begin
                pulses++;
                if ((k % (W + 2)) != W + 1) bad++;
            end
        end
        dreq = 1'b0;
        n_tests++;
        if (pulses !== 4) begin
            n_fail++; $display("FAIL b2b_pulse_count: got %0d expected 4", pulses);
        end
        n_tests++;
        if (bad !== 0) begin
            n_fail++; $display("FAIL b2b_pulse_spacing: got %0d misplaced expected 0", bad);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; int lat; int busy;
        logic        p1;
        int          late = 0;
        access(1'b1, 32'h200, 2'b10, 32'h0, rd, lat, busy);
        @(negedge clk);
        dreq = 1'b1; dwrite = 1'b1; daddr = 32'h200; dsize = 2'b10;
        tb_drv = 1'b1; tb_wdata = 32'hCAFEF00D;
        @(posedge clk);
        #1;
        dreq = 1'b0; tb_drv = 1'b0;
        @(negedge clk);
        p1  = !dready_n;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (!dready_n) late++;
        end
        n_tests++;
        if (p1 !== (W == 0)) begin
            n_fail++; $display("FAIL rst_mid_first_cycle_pulse: got %b expected %b", p1, (W == 0));
        end
        n_tests++;
        if (late !== 0) begin
            n_fail++; $display("FAIL rst_mid_no_response: got %0d pulses expected 0", late);
        end
        access(1'b0, 32'h200, 2'b10, 32'h0, rd, lat, busy);
        n_tests++;
        if (rd !== 32'h0) begin
            n_fail++; $display("FAIL rst_mid_store_discarded: got %h expected 00000000", rd);
        end
    endtask

    initial begin
        test_reset();
        test_word();
        test_byte();
        test_half();
        test_out_of_range();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, 4096: backing-store size in 32-bit words (power of two).
REQ-002 Parameter BASE_ADDR, 32'h0000_0000: byte address of word 0.
REQ-003 Parameter WAIT_CYCLES, 2: number of dbusy cycles inserted before each response (0..15).
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 dreq  input  1  request strobe from the core.
REQ-007 dwrite  input  1  1 = store, 0 = load; valid with dreq.
REQ-008 daddr  input  32  byte address; valid with dreq.
REQ-009 dsize  input  2  access size: 00 = byte, 01 = half, 10 = word, 11 = treated as word.
REQ-010 ddata  inout  32  store data from the core; load data from the responder.
REQ-011 dready_n  output  1  active-low response strobe; exactly one cycle per accepted request.
REQ-012 dbusy  output  1  high while an accepted request is in wait states.

Function
REQ-013 FSM states: IDLE, BUSY, RESP.
REQ-014 IDLE with dreq=1 at a clock edge: accept the request and capture daddr, dsize, dwrite and ddata (store data) into holding registers.
REQ-015 After acceptance, go to BUSY if WAIT_CYCLES>0, otherwise go directly to RESP.
REQ-016 BUSY: dbusy=1; a down-counter loaded with WAIT_CYCLES-1 decrements each cycle; when it reaches 0, go to RESP.
REQ-017 RESP: dready_n=0 for exactly one cycle, then return to IDLE.
REQ-018 The earliest next acceptance is the cycle after RESP; dreq asserted during BUSY or RESP is ignored and not queued.
REQ-019 Load latency from acceptance edge to dready_n low = WAIT_CYCLES+1 cycles.
REQ-020 Load: ddata is driven only in RESP with right-justified data.
- byte: lane daddr[1:0] in [7:0]
- half: half daddr[1] in [15:0]
- word: full word
- upper bits zero; no sign extension.
REQ-021 ddata is high-Z in all other states, during stores, and during reset.
REQ-022 Store: commit in the RESP cycle with byte enables.
- byte: ddata[7:0] to lane daddr[1:0]
- half: ddata[15:0] to half daddr[1]
- word: all lanes
- other bytes unchanged.
REQ-023 Alignment: daddr[0] is ignored for half accesses; daddr[1:0] are ignored for word accesses; no fault is raised.
REQ-024 Word index = (daddr-BASE_ADDR)>>2.
REQ-025 Out-of-range address (below BASE_ADDR or at/above BASE_ADDR+4*DEPTH_WORDS): load returns 32'h0 and store is dropped; the handshake completes normally.
REQ-026 dready_n and dbusy are registered outputs, glitch-free.

Reset
REQ-027 With rst=1 at an edge: FSM goes to IDLE, counter clears, dready_n=1, dbusy=0, ddata high-Z.
REQ-028 Reset mid-operation (BUSY or RESP) abandons the request with no response, and any pending store is discarded.
REQ-029 Backing-store contents are not cleared by reset.

Configuration
REQ-030 Macro DMEM_RESPONDER_WAIT_EN defined: wait-state logic (BUSY state, counter, dbusy) is compiled in and behaves per REQ-015/016.
REQ-031 Macro DMEM_RESPONDER_WAIT_EN undefined: BUSY and counter are removed, dbusy is tied 0, WAIT_CYCLES is ignored, and every accepted request goes IDLE -> RESP (load latency 1).

Verification
REQ-032 Macro defined, WAIT_CYCLES=2: word store 0xDEADBEEF @0x100, then word load @0x100 -> dbusy high 2 cycles, dready_n low in 3rd cycle, ddata=0xDEADBEEF.
REQ-033 Byte store 0x5A @0x101 over 0xDEADBEEF, then word load @0x100 -> 0xDEAD5AEF; then byte load @0x103 -> 0x000000DE.
REQ-034 Half load @0x102 of 0xDEAD5AEF -> 0x0000DEAD; half load @0x103 -> same (daddr[0] ignored).
REQ-035 Load @BASE_ADDR+4*DEPTH_WORDS -> handshake completes with ddata=0x0; store there -> no word in range changes.
REQ-036 dreq held high continuously -> exactly one dready_n pulse per WAIT_CYCLES+2 cycles; rst asserted in BUSY -> no dready_n pulse, pending store absent on readback.
REQ-037 Macro undefined -> dbusy always 0 and dready_n low on the cycle after every accepted dreq.
